latch_exerciser: RTL and testbench

LATCH_EXERCISER -- requirements
Module: latch_exerciser

---
 rtl/latch_exerciser_if.sv | 22 ++
 rtl/latch_exerciser.sv | 135 +++++++++++++
 tb/tb_latch_exerciser.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/latch_exerciser_if.sv
// rtl/latch_exerciser_if.sv - signal bundle between a latch exerciser and its controller/latch side
interface latch_exerciser_if;
  logic       start;
  logic       q_in;
  logic       d_out;
  logic       en_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic [2:0] step_idx;

  // master: the environment (run control plus the latch under test); slave: the exerciser
  modport master (
    output start, q_in,
    input  d_out, en_out, busy, done, pass, err_count, step_idx
  );
  modport slave (
    input  start, q_in,
    output d_out, en_out, busy, done, pass, err_count, step_idx
  );
endinterface

// File: rtl/latch_exerciser.sv
// rtl/latch_exerciser.sv - drives an 8-step (En,D) sequence into a D latch and counts Q mismatches
module latch_exerciser #(
  parameter int STEP_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       q_in,
  output logic       d_out,
  output logic       en_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] step_idx
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0] LAST_CNT = 8'(STEP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] step_q, step_d;
  logic [3:0] err_q, err_d;
  logic       exp_q, exp_d;
  logic       mv_q, mv_d;
  logic       en_q, en_d;
  logic       d_q, d_d;
  logic [1:0] first_drv;
  logic [1:0] next_drv;

  // {En, D} for each step of the fixed sequence
  function automatic logic [1:0] step_drive(input logic [2:0] s);
    logic [1:0] r;
    case (s)
      3'd0:    r = 2'b00;
      3'd1:    r = 2'b01;
      3'd2:    r = 2'b10;
      3'd3:    r = 2'b10;
      3'd4:    r = 2'b11;
      3'd5:    r = 2'b00;
      3'd6:    r = 2'b11;
      default: r = 2'b10;
    endcase
    return r;
  endfunction

  assign first_drv = step_drive(3'd0);
  assign next_drv  = step_drive(step_q + 3'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      err_q   <= '0;
      exp_q   <= 1'b0;
      mv_q    <= 1'b0;
      en_q    <= 1'b0;
      d_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      err_q   <= err_d;
      exp_q   <= exp_d;
      mv_q    <= mv_d;
      en_q    <= en_d;
      d_q     <= d_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    err_d   = err_q;
    exp_d   = exp_q;
    mv_d    = mv_q;
    en_d    = en_q;
    d_d     = d_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          step_d  = '0;
          err_d   = '0;
          mv_d    = 1'b0;
          en_d    = first_drv[1];
          d_d     = first_drv[0];
          if (first_drv[1]) begin
            exp_d = first_drv[0];
            mv_d  = 1'b1;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          // q_in is only looked at here, once the step has fully settled
          if (mv_q && (q_in != exp_q) && (err_q != 4'd15)) begin
            err_d = err_q + 4'd1;
          end
          if (step_q == 3'd7) begin
            state_d = DONE;
            step_d  = '0;
            en_d    = 1'b0;
            d_d     = 1'b0;
          end else begin
            step_d = step_q + 3'd1;
            en_d   = next_drv[1];
            d_d    = next_drv[0];
            if (next_drv[1]) begin
              exp_d = next_drv[0];
              mv_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign d_out     = d_q;
  assign en_out    = en_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign pass      = (state_q == DONE) && (err_q == 4'd0);
  assign err_count = err_q;
  assign step_idx  = step_q;

endmodule

// File: tb/tb_latch_exerciser.sv
// tb/tb_latch_exerciser.sv - directed self-checking bench for latch_exerciser
module tb_latch_exerciser;

  logic clk;
  logic rst_n;
  int   mode;
  int   n_tests;
  int   n_fail;
  logic q_ideal;

  logic [1:0] tbl [8] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00, 2'b11, 2'b10};

  latch_exerciser_if lx ();

  latch_exerciser #(.STEP_CYCLES(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (lx.start),
    .q_in      (lx.q_in),
    .d_out     (lx.d_out),
    .en_out    (lx.en_out),
    .busy      (lx.busy),
    .done      (lx.done),
    .pass      (lx.pass),
    .err_count (lx.err_count),
    .step_idx  (lx.step_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // transparent D latch standing in for the device under test
  always_latch begin
    if (lx.en_out) q_ideal = lx.d_out;
  end

  assign lx.q_in = (mode == 0) ? q_ideal : ((mode == 1) ? 1'b0 : 1'b1);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(lx.busy), 0);
    check({tag, "_done"}, 32'(lx.done), 0);
    check({tag, "_pass"}, 32'(lx.pass), 0);
    check({tag, "_err"},  32'(lx.err_count), 0);
    check({tag, "_step"}, 32'(lx.step_idx), 0);
    check({tag, "_en"},   32'(lx.en_out), 0);
    check({tag, "_d"},    32'(lx.d_out), 0);
  endtask

  // start at edge k, then follow edges k+1..k+80 checking drive trace and error progress
  task automatic run_seq(input string tag, input int glitch_at, input int e40, input int e60,
                         input int e_final);
    lx.start = 1'b1;
    tick();
    lx.start = 1'b0;
    check({tag, "_busy0"}, 32'(lx.busy), 1);
    check({tag, "_done0"}, 32'(lx.done), 0);
    check({tag, "_err0"},  32'(lx.err_count), 0);
    check({tag, "_drv0"},  32'({lx.en_out, lx.d_out}), 32'(tbl[0]));
    for (int i = 1; i <= 80; i++) begin
      if (i == glitch_at) lx.start = 1'b1;
      tick();
      lx.start = 1'b0;
      if (i < 80 && ((i % 10) == 0 || (i % 10) == 9)) begin
        check({tag, "_step"}, 32'(lx.step_idx), 32'(i / 10));
        check({tag, "_drv"},  32'({lx.en_out, lx.d_out}), 32'(tbl[i / 10]));
      end
      if (i == 40) check({tag, "_err40"}, 32'(lx.err_count), 32'(e40));
      if (i == 60) check({tag, "_err60"}, 32'(lx.err_count), 32'(e60));
      if (i == 79) begin
        check({tag, "_done79"}, 32'(lx.done), 0);
        check({tag, "_busy79"}, 32'(lx.busy), 1);
      end
    end
    check({tag, "_done80"}, 32'(lx.done), 1);
    check({tag, "_busy80"}, 32'(lx.busy), 0);
    check({tag, "_errf"},   32'(lx.err_count), 32'(e_final));
    check({tag, "_pass"},   32'(lx.pass), (e_final == 0) ? 1 : 0);
    check({tag, "_drvf"},   32'({lx.en_out, lx.d_out}), 0);
    check({tag, "_stepf"},  32'(lx.step_idx), 0);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    mode     = 0;
    rst_n    = 1'b0;
    lx.start = 1'b0;
    tick();
    tick();
    check_idle("reset");

    rst_n = 1'b1;
    tick();
    check_idle("idle_hold");

    run_seq("ideal", 0, 0, 0, 0);
    repeat (3) tick();
    check("done_hold", 32'(lx.done), 1);
    check("pass_hold", 32'(lx.pass), 1);

    mode = 1;
    run_seq("tie0", 35, 0, 2, 3);

    mode = 2;
    run_seq("tie1", 0, 2, 2, 3);

    mode = 0;
    run_seq("restart", 0, 0, 0, 0);

    lx.start = 1'b1;
    tick();
    lx.start = 1'b0;
    repeat (45) tick();
    check("mid_step4", 32'(lx.step_idx), 4);
    rst_n    = 1'b0;
    lx.start = 1'b1;
    tick();
    check_idle("abort");
    rst_n    = 1'b1;
    lx.start = 1'b0;
    tick();
    check_idle("abort_idle");
    run_seq("after_abort", 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
